// File: rtl/bsod_video_pkg.sv
// bsod_video_pkg: shared types and constants for the LPDDR2 video path
package bsod_video_pkg;

    localparam int unsigned FRAME_WORDS_1080P = 2073600;

    typedef struct packed {
        logic        sof;
        logic [23:0] rgb;
    } pix_word_t;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_FETCH,
        FR_DRAIN,
        FR_FLUSH
    } fr_state_t;

endpackage

// File: rtl/sync_fifo_sa.sv
// sync_fifo_sa: single-clock show-ahead FIFO with one-cycle flush
module sync_fifo_sa #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    assign count   = count_q;
    assign full    = count_q == (AW+1)'(DEPTH);
    assign empty   = count_q == '0;
    assign rd_data = mem_q[rd_ptr_q];

    // Pointer/count update; a pop frees the slot a same-cycle push needs when full
    always_comb begin
        do_rd    = rd_en & ~empty & ~flush;
        do_wr    = wr_en & (~full | do_rd) & ~flush;
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(do_wr);
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(do_rd);
        count_d  = flush ? '0 : count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, not reset; contents are only observed when count is non-zero
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/lpddr2_frame_reader.sv
// lpddr2_frame_reader: credit-limited Avalon-MM read master streaming a frame as RGB pixels
module lpddr2_frame_reader
    import bsod_video_pkg::*;
#(
    parameter int                ADDR_W      = 27,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       FRAME_WORDS = FRAME_WORDS_1080P,
    parameter int                FIFO_DEPTH  = 16
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iENABLE,
    input  logic              local_init_done,
    input  logic              avl_waitrequest_n,
    output logic [ADDR_W-1:0] avl_address,
    output logic              avl_read,
    input  logic              avl_readdatavalid,
    input  logic [31:0]       avl_readdata,
    output logic              avl_burstbegin,
    output logic [23:0]       pix_data,
    output logic              pix_sof,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              oBUSY,
    output logic              oFRAME_DONE
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = $clog2(FRAME_WORDS);
    localparam logic [FW-1:0] LAST = FW'(FRAME_WORDS - 1);

    fr_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [FW-1:0]     issue_q, issue_d;
    logic [FW-1:0]     ret_q, ret_d;
    logic [FW-1:0]     pixcnt_q, pixcnt_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       credit_sum;
    logic              fifo_full, fifo_empty, fifo_wr, fifo_rd, fifo_flush;
    logic              run, rd_req, accept;
    pix_word_t         wr_word, rd_word;
    logic              unused_hi;

    assign unused_hi = ^avl_readdata[31:24];

    // Request generation, counters and frame FSM next state
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_d     = issue_q;
        ret_d       = ret_q;
        pixcnt_d    = pixcnt_q;
        run         = iENABLE & local_init_done;
        credit_sum  = {1'b0, outst_q} + {1'b0, fifo_count};
        rd_req      = (state_q == FR_FETCH) & run & (credit_sum < (CW+1)'(FIFO_DEPTH));
        accept      = rd_req & avl_waitrequest_n;
        fifo_wr     = avl_readdatavalid;
        fifo_rd     = ~fifo_empty & pix_ready;
        fifo_flush  = state_q == FR_FLUSH;
        wr_word.sof = ret_q == '0;
        wr_word.rgb = avl_readdata[23:0];
        outst_d     = outst_q + CW'(accept) - CW'(avl_readdatavalid);
        oFRAME_DONE = fifo_rd & (pixcnt_q == LAST);
        if (accept) begin
            addr_d  = (issue_q == LAST) ? BASE_ADDR : addr_q + ADDR_W'(1);
            issue_d = (issue_q == LAST) ? '0 : issue_q + FW'(1);
        end
        if (avl_readdatavalid) ret_d = (ret_q == LAST) ? '0 : ret_q + FW'(1);
        if (fifo_rd) pixcnt_d = (pixcnt_q == LAST) ? '0 : pixcnt_q + FW'(1);
        case (state_q)
            FR_IDLE: if (run) begin
                state_d = FR_FETCH;
                addr_d  = BASE_ADDR;
                issue_d = '0;
                ret_d   = '0;
            end
            FR_FETCH: if (!run) state_d = FR_DRAIN;
            FR_DRAIN: if (outst_q == '0) state_d = FR_FLUSH;
            default: begin
                state_d  = FR_IDLE;
                pixcnt_d = '0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q  <= FR_IDLE;
            addr_q   <= BASE_ADDR;
            issue_q  <= '0;
            ret_q    <= '0;
            pixcnt_q <= '0;
            outst_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            issue_q  <= issue_d;
            ret_q    <= ret_d;
            pixcnt_q <= pixcnt_d;
            outst_q  <= outst_d;
        end
    end

    sync_fifo_sa #(
        .WIDTH($bits(pix_word_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (iCLK),
        .rst_n  (iRST_n),
        .wr_en  (fifo_wr),
        .wr_data(wr_word),
        .rd_en  (fifo_rd),
        .rd_data(rd_word),
        .flush  (fifo_flush),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign avl_address    = addr_q;
    assign avl_read       = rd_req;
    assign avl_burstbegin = rd_req;
    assign oBUSY          = state_q != FR_IDLE;
    assign pix_valid      = ~fifo_empty;
    assign pix_data       = fifo_empty ? '0 : rd_word.rgb;
    assign pix_sof        = ~fifo_empty & rd_word.sof;

endmodule

// File: tb/tb_lpddr2_frame_reader.sv
// tb_lpddr2_frame_reader: directed bench with a latency-programmable Avalon memory model
module tb_lpddr2_frame_reader;

    localparam logic [26:0] BASE = 27'h100;
    localparam int          FW   = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ien, init_done, wr_n, rdv, pix_ready;
    logic [31:0] rdata;
    logic [26:0] avl_address;
    logic        avl_read, avl_burstbegin;
    logic [23:0] pix_data;
    logic        pix_sof, pix_valid, busy, frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int lat   = 2;

    int acc_cnt = 0, rdv_cnt = 0, pop_cnt = 0, sof_cnt = 0, done_cnt = 0;
    int exp_iss = 0, exp_pix = 0;
    logic        pend = 1'b0;
    logic [26:0] pend_addr = '0;

    always #5 clk = ~clk;

    lpddr2_frame_reader #(
        .ADDR_W(27),
        .BASE_ADDR(BASE),
        .FRAME_WORDS(FW),
        .FIFO_DEPTH(16)
    ) dut (
        .iCLK(clk),
        .iRST_n(rst_n),
        .iENABLE(ien),
        .local_init_done(init_done),
        .avl_waitrequest_n(wr_n),
        .avl_address(avl_address),
        .avl_read(avl_read),
        .avl_readdatavalid(rdv),
        .avl_readdata(rdata),
        .avl_burstbegin(avl_burstbegin),
        .pix_data(pix_data),
        .pix_sof(pix_sof),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .oBUSY(busy),
        .oFRAME_DONE(frame_done)
    );

    function automatic logic [31:0] mem_word(input logic [26:0] a);
        return {8'hC3, (a[23:0] * 24'd7) ^ 24'h3C3C3C};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [26:0] addr;
        int          due;
    } req_t;

    req_t q[$];
    int   cyc = 0;

    // Memory: an accept at edge c returns data sampled by the DUT at edge c+lat
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            rdv   <= 1'b0;
            rdata <= '0;
        end else begin
            rdv <= 1'b0;
            if (q.size() > 0 && q[0].due <= cyc) begin
                rdv   <= 1'b1;
                rdata <= mem_word(q[0].addr);
                void'(q.pop_front());
            end
            if (avl_read && wr_n) q.push_back('{addr: avl_address, due: cyc + lat - 1});
            cyc <= cyc + 1;
        end
    end

    // Observer: issue order, request hold, popped pixel stream, overflow guard
    always @(negedge clk) begin
        if (rst_n) begin
            if (!busy) begin
                exp_iss = 0;
                exp_pix = 0;
            end
            if (avl_read && wr_n) begin
                chk("issue_addr", 32'(avl_address), 32'(BASE + 27'(exp_iss % FW)));
                exp_iss++;
                acc_cnt++;
            end
            if (pend && ien && init_done) begin
                chk("hold_read", 32'(avl_read), 32'd1);
                chk("hold_addr", 32'(avl_address), 32'(pend_addr));
            end
            pend      = avl_read && !wr_n;
            pend_addr = avl_address;
            if (rdv) rdv_cnt++;
            if (dut.fifo_wr) chk("no_wr_full", 32'(dut.fifo_full), 32'd0);
            if (pix_valid && pix_ready) begin
                chk("pix_data", 32'(pix_data), 32'(mem_word(BASE + 27'(exp_pix % FW)) & 32'hFFFFFF));
                chk("pix_sof", 32'(pix_sof), 32'(exp_pix % FW == 0));
                chk("frame_done", 32'(frame_done), 32'(exp_pix % FW == FW - 1));
                if (pix_sof) sof_cnt++;
                if (frame_done) done_cnt++;
                exp_pix++;
                pop_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        ien = 1'b0;
        pix_ready = 1'b1;
        for (int i = 0; i < 300 && busy; i++) tick();
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic wait_pops(input int target, input string tag);
        int i;
        for (i = 0; i < 500 && pop_cnt < target; i++) tick();
        chk(tag, 32'(pop_cnt >= target), 32'd1);
    endtask

    initial begin
        int n0, r0, a0, bad;
        rst_n = 1'b0; ien = 1'b1; init_done = 1'b0; wr_n = 1'b1; pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read", 32'(avl_read), 32'd0);
        chk("rst_burst", 32'(avl_burstbegin), 32'd0);
        chk("rst_addr", 32'(avl_address), 32'h100);
        chk("rst_valid", 32'(pix_valid), 32'd0);
        chk("rst_sof", 32'(pix_sof), 32'd0);
        chk("rst_data", 32'(pix_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (avl_read || busy) bad++;
        end
        chk("idle_no_init", 32'(bad), 32'd0);

        init_done = 1'b1;
        chk("pre_start_read", 32'(avl_read), 32'd0);
        tick();
        chk("start_read", 32'(avl_read), 32'd1);
        chk("start_addr", 32'(avl_address), 32'h100);
        tick();
        chk("ret_lat_1", 32'(pix_valid), 32'd0);
        tick();
        chk("ret_lat_2", 32'(pix_valid), 32'd0);
        tick();
        chk("ret_lat_3", 32'(pix_valid), 32'd1);
        chk("first_sof", 32'(pix_sof), 32'd1);
        wait_pops(32, "basic_pops");
        chk("basic_done_cnt", 32'(done_cnt), 32'd2);
        chk("basic_sof_cnt", 32'(sof_cnt), 32'd2);

        go_idle();
        pix_ready = 1'b0;
        a0 = acc_cnt;
        ien = 1'b1;
        repeat (200) tick();
        chk("bp_accepts", 32'(acc_cnt - a0), 32'd16);
        chk("bp_read_low", 32'(avl_read), 32'd0);
        chk("bp_valid", 32'(pix_valid), 32'd1);
        n0 = pop_cnt;
        pix_ready = 1'b1;
        wait_pops(n0 + 40, "bp_resume_pops");

        for (int i = 0; i < 150; i++) begin
            wr_n = 1'($urandom_range(0, 1));
            tick();
        end
        wr_n = 1'b1;
        n0 = pop_cnt;
        wait_pops(n0 + 20, "wreq_pops");

        go_idle();
        lat = 3;
        ien = 1'b1;
        repeat (20) tick();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (!(avl_read && wr_n && rdv) || dut.outst_q != 3) bad++;
            tick();
        end
        chk("steady_outstanding", 32'(bad), 32'd0);

        go_idle();
        lat = 4;
        n0 = pop_cnt;
        ien = 1'b1;
        for (int i = 0; i < 100 && pop_cnt < n0 + 5; i++) tick();
        chk("dis_five_pops", 32'(pop_cnt - n0), 32'd5);
        ien = 1'b0;
        pix_ready = 1'b0;
        r0 = rdv_cnt;
        a0 = acc_cnt;
        for (int i = 0; i < 100 && busy; i++) tick();
        chk("dis_idle", 32'(busy), 32'd0);
        chk("dis_returns", 32'(rdv_cnt - r0), 32'd4);
        chk("dis_no_accepts", 32'(acc_cnt - a0), 32'd0);
        chk("dis_flushed", 32'(pix_valid), 32'd0);
        lat = 2;
        ien = 1'b1;
        for (int i = 0; i < 50 && !pix_valid; i++) tick();
        chk("reen_valid", 32'(pix_valid), 32'd1);
        chk("reen_sof", 32'(pix_sof), 32'd1);
        chk("reen_data", 32'(pix_data), 32'(mem_word(BASE) & 32'hFFFFFF));
        pix_ready = 1'b1;
        n0 = pop_cnt;
        wait_pops(n0 + 20, "reen_pops");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
